// File: rtl/median_output_framer.sv
// Realigns pixel strobes to the 3x3 median filter output, tracks raster position,
// crops or replaces incomplete-window borders and streams results through a FIFO.
module median_output_framer #(
  parameter int         WIDTH       = 256,
  parameter int         HEIGHT      = 256,
  parameter int         LATENCY     = 2,
  parameter int         BORDER_MODE = 0,
  parameter logic [7:0] BORDER_VAL  = 8'd0,
  parameter int         FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic       sof,
  input  logic [7:0] med_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_user,
  output logic       m_last,
  output logic       frame_done,
  output logic       overflow,
  output logic       sync_err
);

  localparam int CW = (WIDTH < 4) ? 2 : $clog2(WIDTH);
  localparam int RW = (HEIGHT < 4) ? 2 : $clog2(HEIGHT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [LATENCY-1:0] vld_dl, sof_dl;
  logic               d_valid, d_sof;

  logic [CW-1:0] cnt_col, pos_col;
  logic [RW-1:0] cnt_row, pos_row;
  logic          beat, err, frame_end, interior;
  logic          push;
  logic [9:0]    push_entry;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          full, do_push, do_pop, drop;
  logic [9:0]    head_next;

  // Alignment stage: strobes delayed to line up with med_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_dl <= '0;
      sof_dl <= '0;
    end else begin
      vld_dl[0] <= pix_valid;
      sof_dl[0] <= pix_valid & sof;
      for (int i = 1; i < LATENCY; i++) begin
        vld_dl[i] <= vld_dl[i-1];
        sof_dl[i] <= sof_dl[i-1];
      end
    end
  end

  assign d_valid = vld_dl[LATENCY-1];
  assign d_sof   = sof_dl[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Beat qualification and position of the newest window pixel
  always_comb begin
    beat    = 1'b0;
    err     = 1'b0;
    pos_col = cnt_col;
    pos_row = cnt_row;
    case (state)
      IDLE: begin
        if (d_valid) begin
          if (d_sof) begin
            beat    = 1'b1;
            pos_col = '0;
            pos_row = '0;
          end else begin
            err = 1'b1;
          end
        end
      end
      default: begin
        if (d_valid) begin
          beat = 1'b1;
          if (d_sof) begin
            err     = 1'b1;
            pos_col = '0;
            pos_row = '0;
          end
        end else begin
          err = 1'b1;
        end
      end
    endcase
    frame_end = beat && (pos_col == COL_MAX) && (pos_row == ROW_MAX);
  end

  always_comb begin
    state_next = state;
    if (frame_end)  state_next = IDLE;
    else if (beat)  state_next = ACTIVE;
  end

  always_comb begin
    interior   = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    push       = 1'b0;
    push_entry = '0;
    if (BORDER_MODE == 0) begin
      push       = beat && interior;
      push_entry = {(pos_row == RW'(2)) && (pos_col == CW'(2)), pos_col == COL_MAX, med_in};
    end else begin
      push       = beat;
      push_entry = {(pos_row == '0) && (pos_col == '0), pos_col == COL_MAX,
                    interior ? med_in : BORDER_VAL};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_col <= '0;
      cnt_row <= '0;
    end else if (beat) begin
      if (pos_col == COL_MAX) begin
        cnt_col <= '0;
        cnt_row <= (pos_row == ROW_MAX) ? '0 : pos_row + RW'(1);
      end else begin
        cnt_col <= pos_col + CW'(1);
        cnt_row <= pos_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      overflow   <= overflow | drop;
      sync_err   <= sync_err | err;
    end
  end

  // Output FIFO stage: head entry is pre-registered onto the stream outputs
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = m_valid & m_ready;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if (do_push && (wr_ptr == rd_next)) head_next = push_entry;
      else                                head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_user  <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_next;
      count   <= count_next;
      m_valid <= (count_next != '0);
      {m_user, m_last, m_data} <= head_next;
    end
  end

endmodule

// File: tb/tb_median_output_framer.sv
// Bench for median_output_framer: two 4x4 instances (crop/depth 16, replace/depth 4)
// driven from a shared beat table, outputs checked against scoreboard queues.
module tb_median_output_framer;

  logic       clk, rst, pix_valid, sof;
  logic [7:0] med_in;
  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1, m_ready0, m_ready1;
  logic       m_user0, m_user1, m_last0, m_last1;
  logic       frame_done0, frame_done1, overflow0, overflow1, sync_err0, sync_err1;

  median_output_framer #(.WIDTH(4), .HEIGHT(4), .LATENCY(2), .BORDER_MODE(0),
                         .BORDER_VAL(8'd0), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .med_in(med_in),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0), .m_user(m_user0),
    .m_last(m_last0), .frame_done(frame_done0), .overflow(overflow0), .sync_err(sync_err0));

  median_output_framer #(.WIDTH(4), .HEIGHT(4), .LATENCY(2), .BORDER_MODE(1),
                         .BORDER_VAL(8'd0), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .med_in(med_in),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_user(m_user1),
    .m_last(m_last1), .frame_done(frame_done1), .overflow(overflow1), .sync_err(sync_err1));

  typedef struct {
    logic       sof;
    logic [7:0] med;
    logic       e0_push;
    logic [9:0] e0;   // {user, last, data} expected from crop instance
    logic [9:0] e1;   // {user, last, data} expected from replace instance
  } vec_t;

  vec_t       tbl [16];
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [7:0] hist0, hist1;
  int         checks = 0, errors = 0;
  int         fd0 = 0, fd1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid0 && m_ready0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_extra: got %h, required no output", {m_user0, m_last0, m_data0});
        end else begin
          logic [9:0] e;
          e = q0.pop_front();
          if ({m_user0, m_last0, m_data0} != e) begin
            errors++;
            $display("FAIL out0: got %h, required %h", {m_user0, m_last0, m_data0}, e);
          end
        end
      end
      if (m_valid1 && m_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1_extra: got %h, required no output", {m_user1, m_last1, m_data1});
        end else begin
          logic [9:0] e;
          e = q1.pop_front();
          if ({m_user1, m_last1, m_data1} != e) begin
            errors++;
            $display("FAIL out1: got %h, required %h", {m_user1, m_last1, m_data1}, e);
          end
        end
      end
      if (frame_done0) fd0++;
      if (frame_done1) fd1++;
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // med_in trails the pixel strobe by two cycles, like the filter pipeline
  task automatic step(input logic pv, input logic sf, input logic [7:0] tag);
    pix_valid = pv;
    sof       = sf;
    med_in    = hist1;
    hist1     = hist0;
    hist0     = tag;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int nbeats, input int ready1_at);
    for (int i = 0; i < nbeats; i++) begin
      if (i == ready1_at) m_ready1 = 1'b1;
      if (tbl[i].e0_push) q0.push_back(tbl[i].e0);
      q1.push_back(tbl[i].e1);
      step(1'b1, tbl[i].sof, tbl[i].med);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      step(1'b0, 1'b0, 8'd0);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: left q0=%0d q1=%0d, required 0", q0.size(), q1.size());
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic in_win;
      in_win        = (i == 10 || i == 11 || i == 14 || i == 15);
      tbl[i].sof    = (i == 0);
      tbl[i].med    = 8'(i);
      tbl[i].e0_push = in_win;
      tbl[i].e0     = {i == 10, i == 11 || i == 15, 8'(i)};
      tbl[i].e1     = {i == 0, i == 3 || i == 7 || i == 11 || i == 15, in_win ? 8'(i) : 8'd0};
    end

    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; med_in = 8'd0;
    hist0 = 8'd0; hist1 = 8'd0; m_ready0 = 1'b1; m_ready1 = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'd0);
    chk("rst_m_valid0", m_valid0, 0);
    chk("rst_m_valid1", m_valid1, 0);
    chk("rst_m_data1", m_data1, 0);
    chk("rst_flags", {frame_done0, overflow0, sync_err0, frame_done1, overflow1, sync_err1}, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'd0);

    // crop and replace on one clean frame, consumer always ready
    fd0 = 0; fd1 = 0;
    run_frame(16, -1);
    drain();
    chk("s1_frame_done0", fd0, 1);
    chk("s2_frame_done1", fd1, 1);
    chk("s1_flags0", {overflow0, sync_err0}, 0);
    chk("s2_flags1", {overflow1, sync_err1}, 0);
    chk("s2_m_valid1_idle", m_valid1, 0);

    // replace FIFO fills, then push and pop coincide while full
    fd0 = 0; fd1 = 0;
    m_ready1 = 1'b0;
    run_frame(16, 6);
    drain();
    chk("s4_overflow1", overflow1, 0);
    chk("s4_frame_done1", fd1, 1);

    // consumer stalled for the whole frame: only the first four survive
    fd0 = 0; fd1 = 0;
    m_ready1 = 1'b0;
    run_frame(16, -1);
    while (q1.size() > 4) void'(q1.pop_back());
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'd0);
    chk("s3_overflow1", overflow1, 1);
    chk("s3_m_valid1_held", m_valid1, 1);
    chk("s3_overflow0", overflow0, 0);
    m_ready1 = 1'b1;
    drain();
    chk("s3_m_valid1_after", m_valid1, 0);
    chk("s3_frame_done1", fd1, 1);

    // sof reasserted after six beats, then a full frame
    fd0 = 0; fd1 = 0;
    run_frame(6, -1);
    run_frame(16, -1);
    drain();
    chk("s5_sync_err0", sync_err0, 1);
    chk("s5_sync_err1", sync_err1, 1);
    chk("s5_frame_done0", fd0, 1);

    // reset mid-frame with three entries queued
    m_ready1 = 1'b0;
    run_frame(5, -1);
    rst = 1'b1;
    #1;
    chk("s6_m_valid1", m_valid1, 0);
    chk("s6_overflow1", overflow1, 0);
    chk("s6_sync_err", {sync_err0, sync_err1}, 0);
    q0.delete();
    q1.delete();
    hist0 = 8'd0; hist1 = 8'd0;
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    m_ready1 = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("s6_m_valid1_empty", m_valid1, 0);
    fd0 = 0; fd1 = 0;
    run_frame(16, -1);
    drain();
    chk("s6_frame_done", fd0 + fd1, 2);
    chk("s6_flags", {overflow0, sync_err0, overflow1, sync_err1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_output_framer.md
Name: median_output_framer

Overview:
- Sits directly downstream of the 3x3 median filter.
- Takes the filter's raw, unstalled Median byte stream and realigns a pixel-valid/start-of-frame strobe to it across the filter's pipeline latency.
- Tracks the raster position of each result and either crops or replaces border results whose 3x3 window is incomplete.
- Delivers the result through a small FIFO on a valid/ready stream with start-of-frame and end-of-line markers.

Parameters:
- WIDTH, 256: pixels per line. Must equal the filter's line-buffer COUNT.
- HEIGHT, 256: lines per frame.
- LATENCY, 2: clock cycles from a pixel strobe at the filter input to the matching med_in. Must be ≥1.
- BORDER_MODE, 0: 0 = crop (emit interior only); 1 = replace (emit every beat, border forced to BORDER_VAL).
- BORDER_VAL, 0: 8-bit replacement value used in mode 1.
- FIFO_DEPTH, 16: output FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_valid  in  1  pixel presented to the filter this cycle; asserted continuously within a frame
- sof  in  1  first pixel of frame; qualified by pix_valid
- med_in  in  8  filter Median output
- m_data  out  8  output pixel
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts; transfer occurs when m_valid && m_ready
- m_user  out  1  first emitted pixel of frame
- m_last  out  1  last emitted pixel of line
- frame_done  out  1  one-cycle pulse after the last beat of a frame is processed
- overflow  out  1  sticky: a beat was dropped because the FIFO was full
- sync_err  out  1  sticky: framing error

Behaviour:
- Reset (async, asserts immediately): all outputs 0; delay line, counters and FIFO cleared; state = IDLE. Outputs are registered.
- Alignment: pix_valid and sof pass through a LATENCY-stage shift register, producing d_valid and d_sof, which are aligned with med_in. Only d_valid beats are processed.
- Counters: col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the newest pixel of the window. Window centre = (row-1, col-1). interior = row≥2 && col≥2.
- State IDLE:
  - d_valid && d_sof → counters = (0,0) for this beat; go to ACTIVE.
  - d_valid without d_sof → beat dropped; sync_err set.
- State ACTIVE:
  - Each d_valid beat increments col. At col==WIDTH-1, col wraps to 0 and row increments.
  - Beat at (HEIGHT-1, WIDTH-1) → frame_done pulses next cycle; go to IDLE.
  - d_sof while ACTIVE → sync_err set; counters restart at (0,0) with this beat.
  - d_valid low while ACTIVE → sync_err set; counters hold. The filter does not stall, so a gap misaligns windows.
- Push rules, BORDER_MODE 0:
  - Push only interior beats, with data = med_in.
  - user = (row==2 && col==2).
  - last = (col==WIDTH-1).
- Push rules, BORDER_MODE 1:
  - Push every beat, with data = interior ? med_in : BORDER_VAL.
  - user = (row==0 && col==0).
  - last = (col==WIDTH-1).
- FIFO:
  - 10-bit entries {user, last, data}.
  - Push into an empty FIFO → m_valid rises the following cycle.
  - m_data/m_user/m_last hold stable while m_valid && !m_ready.
  - Full && push && !pop → beat dropped; overflow set.
  - Full && push && pop → both occur; no overflow.
  - Empty: pop ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on rst.
- Reset mid-frame discards all FIFO contents and pending delay-line beats.

Test Plan:
1. WIDTH=HEIGHT=4, LATENCY=2, mode 0, m_ready=1; sof + 16 continuous beats, med_in = beat index → exactly 4 outputs: 10 (user=1), 11 (last=1), 14, 15 (last=1); frame_done pulses once; flags 0.
2. Same stimulus, mode 1, BORDER_VAL=0 → 16 outputs, all 0 except 10, 11, 14, 15; user on the first output; last on outputs 4, 8, 12, 16.
3. Mode 1, FIFO_DEPTH=4, m_ready=0 throughout the frame → overflow=1. Then raise m_ready → exactly 4 outputs, {0,0,0,0} with user on the first; m_valid then falls.
4. FIFO full with m_ready=1 and a push in the same cycle → occupancy unchanged; overflow stays 0; data order preserved.
5. sof reasserted after 6 beats → sync_err=1; the following complete frame produces output identical to scenario 1.
6. Assert rst with 3 entries in the FIFO and the frame half done → m_valid, overflow, sync_err = 0 immediately; the next frame is processed correctly; no stale entries emitted.
